// File: rtl/key_entry.sv
// Debounced keypad event stage with a 4-digit BCD entry buffer.
// Optional auto-repeat: define KEY_ENTRY_AUTOREPEAT_EN.
//
// Ports:
//   clk, rst (async, active low)
//   SWC[3:0]       column sense lines, active low
//   key[3:0]       registered key code from the scanner
//   key_valid      one-cycle pulse per accepted key event
//   key_code[3:0]  code of the last accepted event
//   digits[15:0]   four BCD digits, newest in [3:0]
//   count[2:0]     number of digits entered, 0..4
//   value[15:0]    BCD snapshot captured on enter
//   done           one-cycle pulse when enter is processed
module key_entry #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned REPEAT   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  SWC,
  input  logic [3:0]  key,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  count,
  output logic [15:0] value,
  output logic        done
);

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS,
    S_HELD,
    S_REL
  } state_t;

  logic [1:0] fc;
  logic       hit;
  logic       tick;
  logic       down;
  logic       pf;
  logic       rep;
  state_t     st;
  logic [3:0] fcnt;

  assign tick = (fc == 2'd3);
  assign down = (SWC != 4'hF);
  // Frame is pressed if any of its four cycles, tick included, saw a key.
  assign pf   = hit | down;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fc  <= 2'd0;
      hit <= 1'b0;
    end else begin
      fc  <= fc + 2'd1;
      hit <= tick ? 1'b0 : pf;
    end
  end

`ifdef KEY_ENTRY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT + 1);
  localparam logic [RW-1:0] RP = RW'(REPEAT);

  logic [RW-1:0] rcnt;

  assign rep = tick & pf & (st == S_HELD) &
               (rcnt + RW'(1) == RP);

  // Held at zero outside HELD, so every entry to HELD restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt <= '0;
    end else if (st != S_HELD) begin
      rcnt <= '0;
    end else if (tick && pf) begin
      rcnt <= rep ? '0 : rcnt + RW'(1);
    end
  end
`else
  logic [31:0] unused_repeat;
  assign unused_repeat = REPEAT;
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= S_IDLE;
      fcnt      <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd11;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        unique case (st)
          S_IDLE: begin
            if (pf) begin
              if (DB == 4'd1) begin
                st        <= S_HELD;
                fcnt      <= 4'd0;
                key_valid <= 1'b1;
                key_code  <= key;
              end else begin
                st   <= S_PRESS;
                fcnt <= 4'd1;
              end
            end
          end
          S_PRESS: begin
            if (!pf) begin
              st   <= S_IDLE;
              fcnt <= 4'd0;
            end else if (fcnt + 4'd1 == DB) begin
              st        <= S_HELD;
              fcnt      <= 4'd0;
              key_valid <= 1'b1;
              key_code  <= key;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
          S_HELD: begin
            if (!pf) begin
              if (DB == 4'd1) begin
                st <= S_IDLE;
              end else begin
                st   <= S_REL;
                fcnt <= 4'd1;
              end
            end else if (rep) begin
              key_valid <= 1'b1;
              key_code  <= key;
            end
          end
          S_REL: begin
            if (pf) begin
              // Release bounce: back to HELD without a new event.
              st   <= S_HELD;
              fcnt <= 4'd0;
            end else if (fcnt + 4'd1 == DB) begin
              st   <= S_IDLE;
              fcnt <= 4'd0;
            end else begin
              fcnt <= fcnt + 4'd1;
            end
          end
          default: begin
            st   <= S_IDLE;
            fcnt <= 4'd0;
          end
        endcase
      end
    end
  end

  logic is_dig;
  logic is_bs;
  logic is_clr;
  logic is_ent;

  assign is_dig = (key_code <= 4'd9);
  assign is_bs  = (key_code == 4'd10);
  assign is_clr = (key_code == 4'd11);
  assign is_ent = (key_code >= 4'd12);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits <= 16'h0000;
      count  <= 3'd0;
      value  <= 16'h0000;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (key_valid) begin
        unique case (1'b1)
          is_dig: begin
            if (count < 3'd4) begin
              digits <= {digits[11:0], key_code};
              count  <= count + 3'd1;
            end
          end
          is_bs: begin
            if (count != 3'd0) begin
              digits <= {4'h0, digits[15:4]};
              count  <= count - 3'd1;
            end
          end
          is_clr: begin
            digits <= 16'h0000;
            count  <= 3'd0;
          end
          is_ent: begin
            value  <= digits;
            digits <= 16'h0000;
            count  <= 3'd0;
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Scoreboard bench for key_entry.
// DEBOUNCE=2, REPEAT=3; auto-repeat case under KEY_ENTRY_AUTOREPEAT_EN.
module tb_key_entry;

  logic        clk;
  logic        rst;
  logic [3:0]  SWC;
  logic [3:0]  key;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic [2:0]  count;
  logic [15:0] value;
  logic        done;

  key_entry #(
    .DEBOUNCE(2),
    .REPEAT  (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SWC      (SWC),
    .key      (key),
    .key_valid(key_valid),
    .key_code (key_code),
    .digits   (digits),
    .count    (count),
    .value    (value),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] dg;
    logic [2:0]  cnt;
    logic        dn;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Edges since reset release; frames end on edges where cyc%4==0.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop on each key_valid, check buffer a cycle later.
  always @(negedge clk) begin
    if (rst && key_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got code %0d expected none",
                 key_code);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("key_code", 32'(key_code), 32'(e.code));
        @(negedge clk);
        chk("digits", 32'(digits), 32'(e.dg));
        chk("count", 32'(count), 32'(e.cnt));
        chk("done", 32'(done), 32'(e.dn));
        if (e.dn) chk("value", 32'(value), 32'(e.val));
      end
    end
  end

  task automatic align();
    @(negedge clk);
    while (cyc % 4 != 0) @(negedge clk);
  endtask

  task automatic hold(input logic [3:0] sw, input int n);
    SWC = sw;
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [3:0] c,
                           input logic [15:0] dg,
                           input logic [2:0] cnt,
                           input logic dn,
                           input logic [15:0] val);
    exp_t e;
    e.code = c;
    e.dg   = dg;
    e.cnt  = cnt;
    e.dn   = dn;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic press(input logic [3:0] k, input int n, input int r,
                       input logic [15:0] dg, input logic [2:0] cnt,
                       input logic dn, input logic [15:0] val);
    expect_ev(k, dg, cnt, dn, val);
    align();
    key = k;
    hold(4'b1101, n);
    hold(4'b1111, r);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_key_valid"}, 32'(key_valid), 32'd0);
    chk({tag, "_key_code"}, 32'(key_code), 32'd11);
    chk({tag, "_digits"}, 32'(digits), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b0;
    SWC = 4'hF;
    key = 4'd0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b1;

    // First press held 3 frames: one event.
    press(4'd5, 3, 3, 16'h0005, 3'd1, 1'b0, 16'h0);
    press(4'd11, 2, 2, 16'h0000, 3'd0, 1'b0, 16'h0);
    press(4'd1, 2, 2, 16'h0001, 3'd1, 1'b0, 16'h0);
    press(4'd2, 2, 2, 16'h0012, 3'd2, 1'b0, 16'h0);
    press(4'd3, 2, 2, 16'h0123, 3'd3, 1'b0, 16'h0);
    press(4'd4, 2, 2, 16'h1234, 3'd4, 1'b0, 16'h0);
    press(4'd7, 2, 2, 16'h1234, 3'd4, 1'b0, 16'h0);
    press(4'd10, 2, 2, 16'h0123, 3'd3, 1'b0, 16'h0);
    press(4'd14, 2, 2, 16'h0000, 3'd0, 1'b1, 16'h0123);

    // Release bounce: one pressed frame inside RELEASE window.
    press(4'd9, 3, 1, 16'h0009, 3'd1, 1'b0, 16'h0);
    hold(4'b1101, 1);
    hold(4'b1111, 3);

    // Single-cycle glitch in IDLE.
    align();
    key = 4'd6;
    SWC = 4'b1110;
    @(negedge clk);
    hold(4'b1111, 3);

    // Reset while in PRESS with fcnt=1, key kept held.
    align();
    key = 4'd3;
    hold(4'b0111, 1);
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    expect_ev(4'd3, 16'h0003, 3'd1, 1'b0, 16'h0);
    rst = 1'b1;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (key_valid) begin
        lat = cyc;
        break;
      end
    end
    chk("requal_latency", 32'(lat), 32'd8);
    hold(4'b1111, 3);

`ifdef KEY_ENTRY_AUTOREPEAT_EN
    press(4'd11, 2, 2, 16'h0000, 3'd0, 1'b0, 16'h0);
    expect_ev(4'd8, 16'h0008, 3'd1, 1'b0, 16'h0);
    expect_ev(4'd8, 16'h0088, 3'd2, 1'b0, 16'h0);
    expect_ev(4'd8, 16'h0888, 3'd3, 1'b0, 16'h0);
    expect_ev(4'd8, 16'h8888, 3'd4, 1'b0, 16'h0);
    align();
    key = 4'd8;
    hold(4'b1011, 11);
    hold(4'b1111, 3);
    chk("repeat_count", 32'(count), 32'd4);
`endif

    repeat (8) @(negedge clk);
    chk("pending_events", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
